rca_inc_pipe: RTL and testbench

RCA_INC_PIPE -- requirements
Module: rca_inc_pipe

---
 rtl/ecc_arith_pkg.sv | 14 +
 rtl/fa.sv | 16 +
 rtl/rca_inc_pipe_slice.sv | 31 +++
 rtl/rca_inc_pipe.sv | 134 +++++++++++++
 tb/tb_rca_inc_pipe.sv | 268 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/ecc_arith_pkg.sv
// Shared arithmetic constants: default operand geometry and op encoding.
// Latency: n/a (constants only).
// Backpressure: n/a.
package ecc_arith_pkg;

   // Default operand width and pipeline depth for the incrementer.
   localparam int DEF_WIDTH  = 8;
   localparam int DEF_STAGES = 2;

   // Op encoding carried on the in_dec line.
   localparam logic OP_INC = 1'b0;
   localparam logic OP_DEC = 1'b1;

endpackage

// File: rtl/fa.sv
// Single-bit full adder.
// Latency: combinational.
// Backpressure: n/a.
// Ports: a, b, ci -> s (sum), co (carry out).
module fa (
   input  logic a,
   input  logic b,
   input  logic ci,
   output logic s,
   output logic co
);

   assign s  = a ^ b ^ ci;
   assign co = (a & b) | (a & ci) | (b & ci);

endmodule

// File: rtl/rca_inc_pipe_slice.sv
// One ripple slice of the incrementer: SW chained full adders, addend = dec on every bit.
// Latency: combinational.
// Backpressure: n/a.
// Ports: a (slice operand), dec (addend bit, all-ones for decrement), cin -> sum, cout.
module rca_inc_pipe_slice #(
   parameter int SW = 4
) (
   input  logic [SW-1:0] a,
   input  logic          dec,
   input  logic          cin,
   output logic [SW-1:0] sum,
   output logic          cout
);

   logic [SW:0] c;

   assign c[0] = cin;

   for (genvar i = 0; i < SW; i++) begin : g_bit
      fa u_fa (
         .a  (a[i]),
         .b  (dec),
         .ci (c[i]),
         .s  (sum[i]),
         .co (c[i+1])
      );
   end

   assign cout = c[SW];

endmodule

// File: rtl/rca_inc_pipe.sv
// Pipelined ripple incrementer/decrementer; each stage resolves one WIDTH/STAGES slice.
// Latency: STAGES cycles from accept to out_valid when not stalled.
// Backpressure: whole pipe holds when out_valid & !out_ready; in_ready = !out_valid | out_ready.
// Ports: clk, rst_n (async active-low); in_valid/in_ready/in_data/in_dec operand side;
//        out_valid/out_ready/out_data/out_ovf result side (out_ovf = wrap/limit hit).
// Build option: define RCA_INC_SAT_EN to saturate instead of wrapping (out_ovf still set).
module rca_inc_pipe
   import ecc_arith_pkg::*;
#(
   parameter int WIDTH  = DEF_WIDTH,
   parameter int STAGES = DEF_STAGES
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   input  logic             in_dec,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic             out_ovf
);

   localparam int SW = WIDTH / STAGES;

   if (WIDTH % STAGES != 0) begin : g_bad_split
      $error("rca_inc_pipe: WIDTH must be an integer multiple of STAGES");
   end
   if (WIDTH < 2 || WIDTH > 64) begin : g_bad_width
      $error("rca_inc_pipe: WIDTH must be within 2..64");
   end

   // One global advance: every stage moves together or holds together,
   // which keeps bubbles and ordering trivially correct.
   logic adv;
   assign adv      = !out_valid | out_ready;
   assign in_ready = adv;

   // Link k feeds stage k: valid, partially resolved word, carry into slice k, op.
   logic [STAGES-1:0]            p_vld;
   logic [STAGES-1:0][WIDTH-1:0] p_dat;
   logic [STAGES-1:0]            p_cy;
   logic [STAGES-1:0]            p_dec;

   assign p_vld[0] = in_valid;
   assign p_dat[0] = in_data;
   assign p_dec[0] = in_dec;
   // Increment ripples +1 via carry-in; decrement adds all-ones with carry-in 0.
   assign p_cy[0]  = (in_dec == OP_INC);

   for (genvar k = 0; k < STAGES; k++) begin : g_stage
      logic [SW-1:0]    sum;
      logic             cout;
      logic [WIDTH-1:0] nxt_dat;

      rca_inc_pipe_slice #(.SW(SW)) u_slice (
         .a    (p_dat[k][k*SW +: SW]),
         .dec  (p_dec[k]),
         .cin  (p_cy[k]),
         .sum  (sum),
         .cout (cout)
      );

      // Lower slices are already resolved, upper slices still raw operand bits.
      always_comb begin
         nxt_dat              = p_dat[k];
         nxt_dat[k*SW +: SW]  = sum;
      end

      if (k < STAGES-1) begin : g_mid
         logic             r_vld;
         logic [WIDTH-1:0] r_dat;
         logic             r_cy;
         logic             r_dec;

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vld <= 1'b0;
               r_dat <= '0;
               r_cy  <= 1'b0;
               r_dec <= 1'b0;
            end else if (adv) begin
               r_vld <= p_vld[k];
               r_dat <= nxt_dat;
               r_cy  <= cout;
               r_dec <= p_dec[k];
            end
         end

         assign p_vld[k+1] = r_vld;
         assign p_dat[k+1] = r_dat;
         assign p_cy[k+1]  = r_cy;
         assign p_dec[k+1] = r_dec;
      end else begin : g_last
         logic             fin_ovf;
         logic [WIDTH-1:0] fin_dat;
         logic             r_vld;
         logic [WIDTH-1:0] r_dat;
         logic             r_ovf;

         // Increment overflows on carry out; decrement underflows on missing carry.
         assign fin_ovf = (p_dec[k] == OP_DEC) ? ~cout : cout;

`ifdef RCA_INC_SAT_EN
         always_comb begin
            fin_dat = nxt_dat;
            if (fin_ovf) begin
               fin_dat = (p_dec[k] == OP_DEC) ? '0 : '1;
            end
         end
`else
         assign fin_dat = nxt_dat;
`endif

         always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
               r_vld <= 1'b0;
               r_dat <= '0;
               r_ovf <= 1'b0;
            end else if (adv) begin
               r_vld <= p_vld[k];
               r_dat <= fin_dat;
               r_ovf <= fin_ovf;
            end
         end

         assign out_valid = r_vld;
         assign out_data  = r_dat;
         assign out_ovf   = r_ovf;
      end
   end

endmodule

// File: tb/tb_rca_inc_pipe.sv
// Bench for rca_inc_pipe (WIDTH=8, STAGES=2): directed vectors plus a random stream,
// expected results queued at issue and checked by an independent output monitor.
module tb_rca_inc_pipe;

   logic       clk;
   logic       rst_n;
   logic       in_valid;
   logic       in_ready;
   logic [7:0] in_data;
   logic       in_dec;
   logic       out_valid;
   logic       out_ready;
   logic [7:0] out_data;
   logic       out_ovf;

   int total = 0;
   int bad   = 0;

   logic [8:0] exp_q [$];   // {ovf, data}
   logic       rnd_done;

   rca_inc_pipe #(.WIDTH(8), .STAGES(2)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .in_dec    (in_dec),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data),
      .out_ovf   (out_ovf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", name, act, req);
      end
   endtask

   // Reference behaviour for random traffic.
   function automatic logic [8:0] model(input logic [7:0] d, input logic dec);
      logic [7:0] r;
      logic       ovf;
      if (!dec) begin
         r   = d + 8'd1;
         ovf = (d == 8'hFF);
      end else begin
         r   = d - 8'd1;
         ovf = (d == 8'h00);
      end
`ifdef RCA_INC_SAT_EN
      if (ovf) r = dec ? 8'h00 : 8'hFF;
`endif
      return {ovf, r};
   endfunction

   // Call at posedge+#1; returns at (accept edge)+#1 with in_valid dropped.
   task automatic send(input logic [7:0] d, input logic dec, input logic [7:0] ed, input logic eo);
      int waited = 0;
      in_valid = 1'b1;
      in_data  = d;
      in_dec   = dec;
      forever begin
         @(negedge clk);
         if (in_ready) break;
         waited++;
         if (waited > 200) begin
            total++;
            bad++;
            $display("FAIL accept_timeout: in_ready stuck 0 for data %0h", d);
            in_valid = 1'b0;
            return;
         end
      end
      exp_q.push_back({eo, ed});
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   task automatic drain();
      int n = 0;
      while (exp_q.size() != 0 && n < 300) begin
         @(posedge clk);
         #1;
         n++;
      end
      check("drain_left", exp_q.size(), 0);
   endtask

   // Output monitor: pops on every transfer, and checks hold stability under stall.
   initial begin
      logic       hold;
      logic [7:0] hd;
      logic       ho;
      logic [8:0] e;
      hold = 1'b0;
      hd   = '0;
      ho   = 1'b0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            hold = 1'b0;
         end else begin
            if (hold) begin
               total++;
               if (!(out_valid === 1'b1 && out_data === hd && out_ovf === ho)) begin
                  bad++;
                  $display("FAIL hold_stable: got v=%0b d=%0h o=%0b expected v=1 d=%0h o=%0b",
                           out_valid, out_data, out_ovf, hd, ho);
               end
            end
            hold = out_valid && !out_ready;
            hd   = out_data;
            ho   = out_ovf;
            if (out_valid && out_ready) begin
               total++;
               if (exp_q.size() == 0) begin
                  bad++;
                  $display("FAIL unexpected_output: got d=%0h o=%0b expected none", out_data, out_ovf);
               end else begin
                  e = exp_q.pop_front();
                  if ({out_ovf, out_data} !== e) begin
                     bad++;
                     $display("FAIL result: got d=%0h o=%0b expected d=%0h o=%0b",
                              out_data, out_ovf, e[7:0], e[8]);
                  end
               end
            end
         end
      end
   end

   initial begin
      logic [7:0] d;
      logic       dec;
      logic [8:0] r;

      rst_n     = 1'b0;
      in_valid  = 1'b0;
      in_data   = '0;
      in_dec    = 1'b0;
      out_ready = 1'b1;
      rnd_done  = 1'b0;

      // Reset state
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      check("rst_out_data", out_data, 0);
      check("rst_out_ovf", out_ovf, 0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", in_ready, 1);
      @(posedge clk);
      #1;

      // Single increment, latency 2
      send(8'h0F, 1'b0, 8'h10, 1'b0);
      @(negedge clk);
      check("lat_cycle1_valid", out_valid, 0);
      @(negedge clk);
      check("lat_cycle2_valid", out_valid, 1);
      @(posedge clk);
      #1;
      drain();

      // Back-to-back wrap / limit cases
      send(8'hFF, 1'b0, `ifdef RCA_INC_SAT_EN 8'hFF `else 8'h00 `endif, 1'b1);
      send(8'h00, 1'b1, `ifdef RCA_INC_SAT_EN 8'h00 `else 8'hFF `endif, 1'b1);
      send(8'h80, 1'b1, 8'h7F, 1'b0);
      @(negedge clk);
      check("b2b_valid_a", out_valid, 1);
      @(negedge clk);
      check("b2b_valid_b", out_valid, 1);
      @(posedge clk);
      #1;
      drain();

      // Stream with a 3-cycle downstream stall
      fork
         begin
            for (int i = 0; i < 4; i++) begin
               send(8'h10 + 8'(i), 1'b0, 8'h11 + 8'(i), 1'b0);
            end
         end
         begin
            repeat (2) begin
               @(posedge clk);
               #1;
            end
            out_ready = 1'b0;
            for (int j = 0; j < 3; j++) begin
               @(negedge clk);
               check("stall_in_ready", in_ready, 0);
               check("stall_out_valid", out_valid, 1);
               @(posedge clk);
               #1;
            end
            out_ready = 1'b1;
         end
      join
      drain();

      // Reset with two transactions in flight
      send(8'h22, 1'b0, 8'h23, 1'b0);
      send(8'h33, 1'b1, 8'h32, 1'b0);
      #1;
      rst_n = 1'b0;
      @(negedge clk);
      check("midrst_out_valid", out_valid, 0);
      exp_q.delete();
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      for (int j = 0; j < 4; j++) begin
         @(negedge clk);
         check("postrst_quiet", out_valid, 0);
      end
      @(posedge clk);
      #1;
      send(8'h41, 1'b1, 8'h40, 1'b0);
      @(negedge clk);
      check("postrst_lat1", out_valid, 0);
      @(negedge clk);
      check("postrst_lat2", out_valid, 1);
      @(posedge clk);
      #1;
      drain();

      // Random traffic with random downstream readiness
      fork
         begin
            for (int i = 0; i < 10000; i++) begin
               d   = 8'($urandom);
               dec = 1'($urandom_range(0, 1));
               r   = model(d, dec);
               send(d, dec, r[7:0], r[8]);
               if ($urandom_range(0, 7) == 0) begin
                  @(posedge clk);
                  #1;
               end
            end
            rnd_done = 1'b1;
         end
         begin
            while (!rnd_done) begin
               @(posedge clk);
               #1;
               out_ready = ($urandom_range(0, 3) != 0);
            end
            out_ready = 1'b1;
         end
      join
      drain();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
